// File: rtl/corelet_ctrl_pkg.sv
// rtl/corelet_ctrl_pkg.sv - shared types and constants for the corelet tile sequencer
// Contents: sequencer state enum, MAC instruction codes, default widths and sizes,
// and the helper that clamps the kernel-load to execute gap.
package corelet_ctrl_pkg;

   localparam int ROW    = 8;
   localparam int COL    = 8;
   localparam int ADDR_W = 11;
   localparam int LEN_W  = 8;
   localparam int GAP    = 16;

   localparam logic [1:0] INST_NOP   = 2'b00;
   localparam logic [1:0] INST_KLOAD = 2'b01;
   localparam logic [1:0] INST_EXEC  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_FEED_W,
      S_GAP,
      S_EXEC,
      S_DRAIN,
      S_FIN
   } state_t;

   // Weights must have rippled through the whole array before execute starts,
   // so never wait fewer than row+col cycles whatever gap is configured.
   function automatic int gap_cycles(input int g, input int r, input int c);
      return (g < r + c) ? r + c : g;
   endfunction

endpackage

// File: rtl/xmem_fetch.sv
// rtl/xmem_fetch.sv - xmem read issuer feeding the L0 FIFO, one word in flight
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_go              load i_base / i_count and start issuing
//   i_base, i_count   first xmem address and number of words to fetch
//   i_l0_full         L0 full flag
//   o_xmem_cen        active-low xmem read enable (registered)
//   o_xmem_a          xmem read address (registered)
//   o_l0_wr           L0 write strobe, one cycle after each read (registered)
//   o_last            high in the cycle of the final word's L0 write
module xmem_fetch #(
   parameter int ADDR_W = 11,
   parameter int LEN_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_go,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [LEN_W-1:0]  i_count,
   input  logic              i_l0_full,
   output logic              o_xmem_cen,
   output logic [ADDR_W-1:0] o_xmem_a,
   output logic              o_l0_wr,
   output logic              o_last
);

   logic [LEN_W-1:0]  r_left;
   logic [ADDR_W-1:0] r_next;
   logic [ADDR_W-1:0] r_a;
   logic              r_cen;
   logic              r_wr;
   logic              w_issue;

   // A read may only go out in a cycle with no L0 write, i.e. the cycle after
   // a non-issue cycle; this keeps a single word in flight.
   assign w_issue = (r_left != '0) && !i_l0_full && r_cen;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_left <= '0;
         r_next <= '0;
         r_a    <= '0;
         r_cen  <= 1'b1;
         r_wr   <= 1'b0;
      end else begin
         r_wr <= ~r_cen;
         if (i_go) begin
            r_left <= i_count;
            r_next <= i_base;
            r_cen  <= 1'b1;
         end else if (w_issue) begin
            r_cen  <= 1'b0;
            r_a    <= r_next;
            r_next <= r_next + 1'b1;
            r_left <= r_left - 1'b1;
         end else begin
            r_cen <= 1'b1;
         end
      end
   end

   assign o_xmem_cen = r_cen;
   assign o_xmem_a   = r_a;
   assign o_l0_wr    = r_wr;
   assign o_last     = r_wr && (r_left == '0);

endmodule

// File: rtl/corelet_ctrl.sv
// rtl/corelet_ctrl.sv - sequencer for one full tile pass through the corelet datapath
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   start                              pulse that begins a pass when idle
//   w_base, x_base, p_base, x_len      pass parameters, latched on accepted start
//   busy, done                         pass in progress / end-of-pass pulse
//   xmem_cen, xmem_a                   xmem read port
//   l0_wr, l0_rd, l0_o_full, l0_o_ready  L0 FIFO control and status
//   inst                               MAC instruction (nop / kernel load / execute)
//   ofifo_o_valid, ofifo_rd            OFIFO status and pop
//   pmem_wen, pmem_a                   psum SRAM write port
// All outputs are registered.
module corelet_ctrl
   import corelet_ctrl_pkg::*;
#(
   parameter int row    = ROW,
   parameter int col    = COL,
   parameter int addr_w = ADDR_W,
   parameter int len_w  = LEN_W,
   parameter int gap    = GAP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [addr_w-1:0] w_base,
   input  logic [addr_w-1:0] x_base,
   input  logic [addr_w-1:0] p_base,
   input  logic [len_w-1:0]  x_len,
   output logic              busy,
   output logic              done,
   output logic              xmem_cen,
   output logic [addr_w-1:0] xmem_a,
   output logic              l0_wr,
   output logic              l0_rd,
   input  logic              l0_o_full,
   input  logic              l0_o_ready,
   output logic [1:0]        inst,
   input  logic              ofifo_o_valid,
   output logic              ofifo_rd,
   output logic              pmem_wen,
   output logic [addr_w-1:0] pmem_a
);

   localparam int               GAP_N = gap_cycles(gap, row, col);
   localparam int               GW    = $clog2(GAP_N + 1);
   localparam logic [len_w-1:0] ROW_N = len_w'(row);

   state_t             r_state, w_next;
   logic [addr_w-1:0]  r_x_base, r_p_base;
   logic [len_w-1:0]   r_x_len;
   logic [len_w-1:0]   r_pops;        // L0 pops issued in the current phase
   logic [len_w-1:0]   r_ofifo_pops;
   logic [len_w-1:0]   r_wr_cnt;      // psum writes so far (k)
   logic [GW-1:0]      r_gap;

   logic               r_busy, r_done, r_l0_rd, r_ofifo_rd, r_pmem_wen;
   logic [1:0]         r_inst;
   logic [addr_w-1:0]  r_pmem_a;

   logic               w_busy_nxt, w_done_nxt, w_l0_rd_nxt, w_ofifo_rd_nxt, w_pmem_wen_nxt;
   logic [1:0]         w_inst_nxt;
   logic [addr_w-1:0]  w_pmem_a_nxt;
   logic               w_go, w_gap_end, w_fetch_last;
   logic [addr_w-1:0]  w_fetch_base;
   logic [len_w-1:0]   w_fetch_count;

   assign w_gap_end     = (r_state == S_GAP) && (r_gap == GW'(GAP_N - 1));
   assign w_go          = ((r_state == S_IDLE) && start) || (w_gap_end && (r_x_len != '0));
   assign w_fetch_base  = (r_state == S_IDLE) ? w_base : r_x_base;
   assign w_fetch_count = (r_state == S_IDLE) ? ROW_N  : r_x_len;

   xmem_fetch #(
      .ADDR_W (addr_w),
      .LEN_W  (len_w)
   ) u_fetch (
      .i_clk      (clk),
      .i_rst      (reset),
      .i_go       (w_go),
      .i_base     (w_fetch_base),
      .i_count    (w_fetch_count),
      .i_l0_full  (l0_o_full),
      .o_xmem_cen (xmem_cen),
      .o_xmem_a   (xmem_a),
      .o_l0_wr    (l0_wr),
      .o_last     (w_fetch_last)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start)                  w_next = S_LOAD_W;
         S_LOAD_W: if (w_fetch_last)           w_next = S_FEED_W;
         S_FEED_W: if (r_pops == ROW_N)        w_next = S_GAP;
         S_GAP:    if (w_gap_end)              w_next = (r_x_len == '0) ? S_FIN : S_EXEC;
         S_EXEC:   if (r_pops == r_x_len)      w_next = S_DRAIN;
         S_DRAIN:  if (r_wr_cnt == r_x_len)    w_next = S_FIN;
         S_FIN:                                w_next = S_IDLE;
         default:                              w_next = S_IDLE;
      endcase
   end

   // Output logic (next values of the registered outputs).
   // The ready/valid flags seen here are one cycle older than the pop they
   // gate, so a cycle with a pop is never followed by another pop: that
   // pop may just have emptied the FIFO.
   always_comb begin
      w_busy_nxt     = (w_next != S_IDLE);
      w_done_nxt     = (w_next == S_FIN);
      w_l0_rd_nxt    = 1'b0;
      w_inst_nxt     = INST_NOP;
      w_ofifo_rd_nxt = 1'b0;
      w_pmem_wen_nxt = 1'b1;
      w_pmem_a_nxt   = r_pmem_a;
      case (r_state)
         S_FEED_W: if (l0_o_ready && !r_l0_rd && (r_pops != ROW_N)) begin
            w_l0_rd_nxt = 1'b1;
            w_inst_nxt  = INST_KLOAD;
         end
         S_EXEC: if (l0_o_ready && !r_l0_rd && (r_pops != r_x_len)) begin
            w_l0_rd_nxt = 1'b1;
            w_inst_nxt  = INST_EXEC;
         end
         default: ;
      endcase
      if ((r_state == S_EXEC) || (r_state == S_DRAIN)) begin
         if (ofifo_o_valid && !r_ofifo_rd && (r_ofifo_pops != r_x_len))
            w_ofifo_rd_nxt = 1'b1;
         // Each OFIFO pop lands in psum SRAM one cycle later
         if (r_ofifo_rd) begin
            w_pmem_wen_nxt = 1'b0;
            w_pmem_a_nxt   = r_p_base + addr_w'(r_wr_cnt);
         end
      end
   end

   // Pass parameters, phase counters and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x_base     <= '0;
         r_p_base     <= '0;
         r_x_len      <= '0;
         r_pops       <= '0;
         r_ofifo_pops <= '0;
         r_wr_cnt     <= '0;
         r_gap        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_l0_rd      <= 1'b0;
         r_inst       <= INST_NOP;
         r_ofifo_rd   <= 1'b0;
         r_pmem_wen   <= 1'b1;
         r_pmem_a     <= '0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_x_base <= x_base;
            r_p_base <= p_base;
            r_x_len  <= x_len;
         end
         if ((r_state == S_LOAD_W) || (r_state == S_GAP)) r_pops <= '0;
         else if (w_l0_rd_nxt)                            r_pops <= r_pops + 1'b1;
         if (r_state == S_GAP) r_gap <= r_gap + 1'b1;
         else                  r_gap <= '0;
         if (r_state == S_GAP) begin
            r_ofifo_pops <= '0;
            r_wr_cnt     <= '0;
         end else begin
            if (w_ofifo_rd_nxt)  r_ofifo_pops <= r_ofifo_pops + 1'b1;
            if (!w_pmem_wen_nxt) r_wr_cnt     <= r_wr_cnt + 1'b1;
         end
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_l0_rd    <= w_l0_rd_nxt;
         r_inst     <= w_inst_nxt;
         r_ofifo_rd <= w_ofifo_rd_nxt;
         r_pmem_wen <= w_pmem_wen_nxt;
         r_pmem_a   <= w_pmem_a_nxt;
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign l0_rd    = r_l0_rd;
   assign inst     = r_inst;
   assign ofifo_rd = r_ofifo_rd;
   assign pmem_wen = r_pmem_wen;
   assign pmem_a   = r_pmem_a;

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb/tb_corelet_ctrl.sv - self-checking bench for corelet_ctrl with L0/OFIFO/SRAM environment model
`timescale 1ns/1ps
module tb_corelet_ctrl;
   import corelet_ctrl_pkg::*;

   localparam int AW   = 11;
   localparam int LW   = 8;
   localparam int NROW = 8;
   localparam int NGAP = 16;
   localparam int AMOD = 2048;

   logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [AW-1:0] w_base = '0, x_base = '0, p_base = '0;
   logic [LW-1:0] x_len = '0;
   logic          busy, done, xmem_cen, l0_wr, l0_rd, ofifo_rd, pmem_wen;
   logic [AW-1:0] xmem_a, pmem_a;
   logic [1:0]    inst;
   logic          l0_o_full = 1'b0, l0_o_ready = 1'b0, ofifo_o_valid = 1'b0;

   int total = 0, bad = 0, cyc = 0;

   corelet_ctrl dut (
      .clk(clk), .reset(reset), .start(start),
      .w_base(w_base), .x_base(x_base), .p_base(p_base), .x_len(x_len),
      .busy(busy), .done(done), .xmem_cen(xmem_cen), .xmem_a(xmem_a),
      .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_o_full(l0_o_full), .l0_o_ready(l0_o_ready),
      .inst(inst), .ofifo_o_valid(ofifo_o_valid), .ofifo_rd(ofifo_rd),
      .pmem_wen(pmem_wen), .pmem_a(pmem_a)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc = cyc + 1; end

   // Observed transactions and environment state
   int rd_q[$], l0_q[$], pop_addr[$], pop_inst[$], pw_q[$], res_q[$];
   int n_wr, done_cnt, done_cyc, busy_cnt, n_exec, last_kload, first_exec, last_exec, prev_pa;
   int err_overlap, err_full, err_orphan, err_under, err_inst, err_ounder, err_pa;
   int inflight_a, exp_xlen, lat_lo = 9, lat_hi = 9;
   bit inflight, full_seen, force_full, rand_full_mode, hold_mode;

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      rd_q.delete(); pop_addr.delete(); pop_inst.delete(); pw_q.delete();
      n_wr = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; n_exec = 0;
      last_kload = -1; first_exec = -1; last_exec = -1;
      err_overlap = 0; err_full = 0; err_orphan = 0; err_under = 0;
      err_inst = 0; err_ounder = 0; err_pa = 0;
   endtask

   // Environment: SRAM with 1-cycle read latency, L0 as an address queue,
   // OFIFO as a queue of result ready-times. Inputs are updated mid-cycle.
   initial forever begin
      @(negedge clk);
      if (reset) begin
         l0_q.delete(); res_q.delete();
         inflight = 0; full_seen = 0; prev_pa = 0;
         l0_o_full = 0; l0_o_ready = 0; ofifo_o_valid = 0;
      end else begin
         if (!xmem_cen) begin
            rd_q.push_back(int'(xmem_a));
            if (l0_wr) err_overlap++;
            if (full_seen) err_full++;
         end
         if (inst != INST_NOP && !l0_rd) err_inst++;
         if (l0_rd) begin
            if (l0_q.size() == 0) err_under++;
            else begin
               pop_addr.push_back(l0_q.pop_front());
               pop_inst.push_back(int'(inst));
               if (inst == INST_KLOAD) last_kload = cyc;
               if (inst == INST_EXEC) begin
                  if (first_exec < 0) first_exec = cyc;
                  last_exec = cyc;
                  n_exec++;
                  res_q.push_back(cyc + int'($urandom_range(lat_lo, lat_hi)));
               end
            end
         end
         if (l0_wr) begin
            n_wr++;
            if (!inflight) err_orphan++;
            else l0_q.push_back(inflight_a);
         end
         inflight   = !xmem_cen;
         inflight_a = int'(xmem_a);
         if (ofifo_rd) begin
            if (!ofifo_o_valid || res_q.size() == 0) err_ounder++;
            else void'(res_q.pop_front());
         end
         if (!pmem_wen) pw_q.push_back(int'(pmem_a));
         else if (int'(pmem_a) != prev_pa) err_pa++;
         prev_pa = int'(pmem_a);
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (busy) busy_cnt++;
         full_seen     = force_full || (rand_full_mode && ($urandom_range(0, 3) == 0));
         l0_o_full     = full_seen;
         l0_o_ready    = (l0_q.size() != 0);
         ofifo_o_valid = (res_q.size() != 0) && (res_q[0] <= cyc + 1) &&
                         (!hold_mode || (n_exec == exp_xlen && cyc + 1 >= last_exec + 10));
      end
   end

   task automatic do_pass(input int wb, input int xb, input int pb, input int xl,
                          input int full_dly, input bit hold, input bit poke);
      int  s, n;
      bit  got;
      clear_obs();
      hold_mode = hold; exp_xlen = xl;
      w_base = AW'(wb); x_base = AW'(xb); p_base = AW'(pb); x_len = LW'(xl);
      start = 1; s = cyc;
      @(posedge clk); #2;
      start = 0;
      w_base = AW'($urandom); x_base = AW'($urandom); p_base = AW'($urandom); x_len = LW'($urandom);
      got = 0;
      for (int k = 1; k < 3000 && !got; k++) begin
         if (k == full_dly) force_full = 1;
         if (k == full_dly + 5) force_full = 0;
         start = (poke && k == 15);
         @(posedge clk); #2;
         got = (done_cnt != 0);
      end
      start = 0; force_full = 0;
      repeat (3) @(posedge clk);
      #2;
      chk("timeout", got, 1);
      chk("nreads", rd_q.size(), NROW + xl);
      n = (rd_q.size() < NROW + xl) ? rd_q.size() : NROW + xl;
      for (int i = 0; i < n; i++)
         chk($sformatf("rd_addr%0d", i), rd_q[i], (i < NROW) ? (wb + i) % AMOD : (xb + i - NROW) % AMOD);
      chk("nl0wr", n_wr, NROW + xl);
      chk("npops", pop_addr.size(), NROW + xl);
      n = (pop_addr.size() < NROW + xl) ? pop_addr.size() : NROW + xl;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("pop_addr%0d", i), pop_addr[i], (i < NROW) ? (wb + i) % AMOD : (xb + i - NROW) % AMOD);
         chk($sformatf("pop_inst%0d", i), pop_inst[i], (i < NROW) ? 1 : 2);
      end
      chk("npw", pw_q.size(), xl);
      n = (pw_q.size() < xl) ? pw_q.size() : xl;
      for (int i = 0; i < n; i++)
         chk($sformatf("pw_addr%0d", i), pw_q[i], (pb + i) % AMOD);
      chk("ndone", done_cnt, 1);
      chk("busy_cycles", busy_cnt, done_cyc - s);
      chk("overlap", err_overlap, 0);
      chk("rd_while_full", err_full, 0);
      chk("orphan_wr", err_orphan, 0);
      chk("l0_underflow", err_under, 0);
      chk("inst_no_rd", err_inst, 0);
      chk("ofifo_underflow", err_ounder, 0);
      chk("pmem_a_drift", err_pa, 0);
      chk("l0_empty", l0_q.size(), 0);
      if (xl == 0) chk("gap_to_done", done_cyc - last_kload, NGAP + 1);
      else         chk("gap_to_exec", (first_exec - last_kload) >= NGAP + 2, 1);
      if (hold)    chk("drain_wait", done_cyc > last_exec + 10, 1);
   endtask

   initial begin
      logic [30:0] rst_vals;
      rst_vals = {1'b0, 1'b0, 1'b1, 11'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 11'd0};
      clear_obs();
      reset = 1;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_vals", {busy, done, xmem_cen, xmem_a, l0_wr, l0_rd, inst, ofifo_rd, pmem_wen, pmem_a}, rst_vals);
      reset = 0;
      @(posedge clk); #2;

      do_pass(0, 8, 0, 4, -1, 0, 0);            // basic pass
      do_pass(0, 8, 0, 4, 2, 0, 0);             // L0 full held during LOAD_W
      do_pass(16, 40, 5, 0, -1, 0, 0);          // x_len = 0
      do_pass(32, 64, 100, 5, -1, 1, 0);        // OFIFO results held back
      do_pass(2044, 2046, 2045, 6, -1, 0, 1);   // start while busy, address wrap

      // Asynchronous reset in the middle of EXEC
      clear_obs();
      hold_mode = 0; exp_xlen = 20;
      w_base = 100; x_base = 200; p_base = 300; x_len = 20;
      start = 1;
      @(posedge clk); #2;
      start = 0;
      for (int k = 0; k < 2000 && n_exec < 7; k++) begin @(posedge clk); #3; end
      chk("exec_pops_before_reset", n_exec, 7);
      reset = 1;
      #1;
      chk("reset_mid_exec", {busy, done, xmem_cen, xmem_a, l0_wr, l0_rd, inst, ofifo_rd, pmem_wen, pmem_a}, rst_vals);
      repeat (2) @(posedge clk);
      #2;
      reset = 0;
      @(posedge clk); #2;
      do_pass(100, 200, 300, 20, -1, 0, 0);

      // Randomized passes with random L0 back-pressure and OFIFO latency
      rand_full_mode = 1;
      for (int r = 0; r < 4; r++) begin
         lat_lo = 1;
         lat_hi = int'($urandom_range(2, 20));
         do_pass(int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)),
                 int'($urandom_range(0, AMOD - 1)), int'($urandom_range(1, 12)), -1, 0, 0);
      end
      rand_full_mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
- Sequences one full tile pass through the corelet datapath (L0 input FIFO, MAC array, OFIFO).
- Phases: fetch 8 weight rows from activation/weight SRAM into L0, kernel-load them into the MAC array, stream x_len activation vectors with execute, drain OFIFO results into psum SRAM.
- Sits between the top-level testbench/host sequencer and the corelet plus its two SRAMs; replaces hand-driven inst/l0/ofifo control.

Parameters:
- row, 8, MAC array rows (weight vectors loaded per tile)
- col, 8, MAC array columns
- addr_w, 11, SRAM address width (xmem and pmem)
- len_w, 8, width of x_len / internal counters
- gap, 16, idle cycles between kernel load and execute (must be at least row+col)

Ports:
- clk  in  1  clock, all state rises on posedge
- reset  in  1  asynchronous active-high reset, clears all state and outputs immediately
- start  in  1  one-cycle pulse; begins a pass when idle
- w_base  in  addr_w  xmem address of first weight row
- x_base  in  addr_w  xmem address of first activation vector
- p_base  in  addr_w  pmem address of first psum result
- x_len  in  len_w  number of activation vectors (0 legal)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of pass
- xmem_cen  out  1  active-low xmem chip enable (read only)
- xmem_a  out  addr_w  xmem read address
- l0_wr  out  1  L0 write strobe (xmem data valid this cycle)
- l0_rd  out  1  L0 read strobe
- l0_o_full  in  1  L0 full
- l0_o_ready  in  1  L0 non-empty
- inst  out  2  MAC instruction: 00 nop, 01 kernel load, 10 execute
- ofifo_o_valid  in  1  OFIFO holds a full result row
- ofifo_rd  out  1  OFIFO pop
- pmem_wen  out  1  active-low psum SRAM write enable
- pmem_a  out  addr_w  psum SRAM write address

Behaviour:
- Reset values: busy=0, done=0, xmem_cen=1, xmem_a=0, l0_wr=0, l0_rd=0, inst=00, ofifo_rd=0, pmem_wen=1, pmem_a=0. All outputs registered.
- States: IDLE, LOAD_W, FEED_W, GAP, EXEC, DRAIN, FIN.
- IDLE: on start, latch bases and x_len, busy=1, go to LOAD_W. start while busy is ignored.
- Fetch rule (LOAD_W and EXEC):
  - Issue a read (xmem_cen=0, xmem_a=next) in cycle t only if l0_o_full=0 and l0_wr=0 in cycle t, so at most one word is in flight.
  - l0_wr=1 in cycle t+1 for every read issued at t (1-cycle SRAM latency).
- LOAD_W: issue row reads from w_base upward. After the last read's l0_wr, go to FEED_W.
- FEED_W: l0_rd=1 and inst=01 in each cycle with l0_o_ready=1. Count row pops, then go to GAP.
- GAP: inst=00 for gap cycles, then go to EXEC; if x_len=0, go straight to FIN.
- EXEC, three concurrent activities:
  - Issue x_len reads from x_base.
  - l0_rd=1 with inst=10 whenever l0_o_ready=1 and pops < x_len; otherwise inst=00.
  - Drain continuously: ofifo_rd=1 whenever ofifo_o_valid=1.
  - When all x_len pops are done, go to DRAIN.
- DRAIN: ofifo_rd=1 whenever ofifo_o_valid=1. Each pop gives pmem_wen=0 one cycle later at pmem_a = p_base + k, where k is the drain count. After the x_len-th write, go to FIN.
- FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Counters wrap-free: x_len ≤ 2^len_w - 1; addresses are modulo 2^addr_w.
- Reset asserted mid-pass: immediate return to IDLE with reset values. In-flight SRAM reads are discarded because l0_wr is cleared.

Decomposition:
- Package corelet_ctrl_pkg holds:
  - the state enum;
  - INST_NOP=2'b00, INST_KLOAD=2'b01, INST_EXEC=2'b10;
  - default widths.
- Sub-module xmem_fetch holds the issue/in-flight/l0_wr logic and address counter, reused for the weight and activation phases. It takes base, count, go and l0_o_full, and returns last.

Test Plan:
- Reset then start, w_base=0, x_base=8, p_base=0, x_len=4 -> 8 xmem reads at 0..7, 8 l0_rd with inst=01, 16 nop cycles, 4 reads at 8..11 with inst=10, 4 pmem writes at 0..3, done pulse once.
- Hold l0_o_full=1 for 5 cycles during LOAD_W -> no xmem_cen=0 while full, no write lost, still exactly 8 l0_wr.
- x_len=0 -> no execute, no pmem write, done 1 cycle after GAP ends.
- ofifo_o_valid delayed 10 cycles after last execute -> FSM waits in DRAIN, pmem_a increments only on writes.
- start pulsed while busy -> ignored; pass completes with original parameters.
- Async reset in EXEC (x_len=20, after 7 pops) -> outputs return to reset values without a clock edge; a new start runs a full pass correctly.
